// File: rtl/piezo_arb_pkg.sv
// Shared types and cycle constants for the piezo arbiter.
// The FAST_* set shrinks every timing so that benches run in a few thousand cycles.
package piezo_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FAN,
    S_ERR_BEEP,
    S_ERR_GAP,
    S_BATT_BEEP
  } state_t;

  localparam int ERR_BEEPS = 3;

  localparam int DEF_BEEP_HALF   = 25000;
  localparam int DEF_BEEP_LEN    = 5000000;
  localparam int DEF_GAP_LEN     = 2500000;
  localparam int DEF_FAN_TMO     = 33554432;
  localparam int DEF_BATT_PERIOD = 100000000;

  localparam int FAST_BEEP_HALF   = 4;
  localparam int FAST_BEEP_LEN    = 40;
  localparam int FAST_GAP_LEN     = 20;
  localparam int FAST_FAN_TMO     = 1000;
  localparam int FAST_BATT_PERIOD = 200;

  // Counter width for a given terminal value, never narrower than one bit.
  function automatic int cw(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/beep_tone.sv
// Square-wave tone generator. en is driven one cycle ahead of the beep window,
// so the first enabled edge only arms the counter and tone lines up with the window.
module beep_tone
  import piezo_arb_pkg::*;
#(
  parameter int HALF = DEF_BEEP_HALF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tone
);

  localparam int CW = cw(HALF);

  logic [CW-1:0] cnt;
  logic          armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      armed <= 1'b0;
      tone  <= 1'b0;
    end else if (!en) begin
      cnt   <= '0;
      armed <= 1'b0;
      tone  <= 1'b0;
    end else if (!armed) begin
      armed <= 1'b1;
    end else if (cnt == CW'(HALF - 1)) begin
      cnt  <= '0;
      tone <= ~tone;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/piezo_arb.sv
// Arbiter for the single piezo bender: fanfare player, 3-beep error alert and
// periodic low-battery chirp. One sound at a time, never preempted.
module piezo_arb
  import piezo_arb_pkg::*;
#(
  parameter int BEEP_HALF   = DEF_BEEP_HALF,
  parameter int BEEP_LEN    = DEF_BEEP_LEN,
  parameter int GAP_LEN     = DEF_GAP_LEN,
  parameter int FAN_TMO     = DEF_FAN_TMO,
  parameter int BATT_PERIOD = DEF_BATT_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic fanfare_req,
  input  logic err_req,
  input  logic batt_low,
  input  logic fanfare_done,
  input  logic pz_fan,
  output logic go,
  output logic piezo,
  output logic piezo_n,
  output logic busy
);

  localparam int BL_W = cw(BEEP_LEN);
  localparam int GL_W = cw(GAP_LEN);
  localparam int FT_W = cw(FAN_TMO);
  localparam int HO_W = cw(BATT_PERIOD + 1);
  localparam int EC_W = cw(ERR_BEEPS);

  state_t          state, nxt;
  logic            pend_err, pend_fan;
  logic [BL_W-1:0] beep_cnt;
  logic [GL_W-1:0] gap_cnt;
  logic [FT_W-1:0] fan_cnt;
  logic [HO_W-1:0] holdoff;
  logic [EC_W-1:0] err_cnt;
  logic            fan_p, fan_n, beep_on, tone;

  logic batt_ok, beep_end, gap_end, fan_end, last_err;
  logic start_err, start_fan, in_beep, nxt_beep;

  assign batt_ok  = batt_low && (holdoff == '0);
  assign beep_end = (beep_cnt == BL_W'(BEEP_LEN - 1));
  assign gap_end  = (gap_cnt == GL_W'(GAP_LEN - 1));
  assign fan_end  = fanfare_done || (fan_cnt == FT_W'(FAN_TMO - 1));
  assign last_err = (err_cnt == EC_W'(ERR_BEEPS - 1));
  assign in_beep  = (state == S_ERR_BEEP) || (state == S_BATT_BEEP);

  always_comb begin
    nxt       = state;
    start_err = 1'b0;
    start_fan = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (pend_err) begin
          nxt       = S_ERR_BEEP;
          start_err = 1'b1;
        end else if (pend_fan) begin
          nxt       = S_FAN;
          start_fan = 1'b1;
        end else if (batt_ok) begin
          nxt = S_BATT_BEEP;
        end
      end
      S_FAN:       if (fan_end) nxt = S_IDLE;
      S_ERR_BEEP:  if (beep_end) nxt = S_ERR_GAP;
      S_ERR_GAP:   if (gap_end) nxt = last_err ? S_IDLE : S_ERR_BEEP;
      S_BATT_BEEP: if (beep_end) nxt = S_IDLE;
      default:     nxt = S_IDLE;
    endcase
    nxt_beep = (nxt == S_ERR_BEEP) || (nxt == S_BATT_BEEP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      pend_err <= 1'b0;
      pend_fan <= 1'b0;
      go       <= 1'b0;
      beep_cnt <= '0;
      gap_cnt  <= '0;
      fan_cnt  <= '0;
      holdoff  <= '0;
      err_cnt  <= '0;
    end else begin
      state    <= nxt;
      // A request in the same cycle its flag is consumed re-arms the flag.
      pend_err <= err_req | (pend_err & ~start_err);
      pend_fan <= fanfare_req | (pend_fan & ~start_fan);
      go       <= start_fan;
      beep_cnt <= (in_beep && nxt == state) ? beep_cnt + BL_W'(1) : '0;
      gap_cnt  <= (state == S_ERR_GAP && nxt == S_ERR_GAP) ? gap_cnt + GL_W'(1) : '0;
      fan_cnt  <= (state == S_FAN && nxt == S_FAN) ? fan_cnt + FT_W'(1) : '0;
      if (start_err)
        err_cnt <= '0;
      else if (state == S_ERR_GAP && gap_end)
        err_cnt <= err_cnt + EC_W'(1);
      if (state == S_BATT_BEEP && beep_end)
        holdoff <= HO_W'(BATT_PERIOD);
      else if (holdoff != '0)
        holdoff <= holdoff - HO_W'(1);
    end
  end

  // Drive registers are loaded from the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fan_p   <= 1'b0;
      fan_n   <= 1'b0;
      beep_on <= 1'b0;
    end else begin
      fan_p   <= (nxt == S_FAN) & pz_fan;
      fan_n   <= (nxt == S_FAN) & ~pz_fan;
      beep_on <= nxt_beep;
    end
  end

  beep_tone #(
    .HALF(BEEP_HALF)
  ) u_tone (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (nxt_beep),
    .tone (tone)
  );

  assign piezo   = fan_p | tone;
  assign piezo_n = fan_n | (beep_on & ~tone);
  assign busy    = (state != S_IDLE);

endmodule

// File: tb/tb_piezo_arb.sv
// Directed bench for piezo_arb using the reduced timing set.
`timescale 1ns/1ps
module tb_piezo_arb;
  import piezo_arb_pkg::*;

  localparam int BH = FAST_BEEP_HALF;
  localparam int BL = FAST_BEEP_LEN;
  localparam int GL = FAST_GAP_LEN;
  localparam int FT = FAST_FAN_TMO;
  localparam int BP = FAST_BATT_PERIOD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fanfare_req = 1'b0, err_req = 1'b0, batt_low = 1'b0;
  logic fanfare_done = 1'b0, pz_fan = 1'b0;
  logic go, piezo, piezo_n, busy;

  int n_checks = 0;
  int n_pass = 0;

  piezo_arb #(
    .BEEP_HALF(BH), .BEEP_LEN(BL), .GAP_LEN(GL), .FAN_TMO(FT), .BATT_PERIOD(BP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fanfare_req(fanfare_req), .err_req(err_req),
    .batt_low(batt_low), .fanfare_done(fanfare_done), .pz_fan(pz_fan),
    .go(go), .piezo(piezo), .piezo_n(piezo_n), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    fanfare_req = 1'b0; err_req = 1'b0; batt_low = 1'b0;
    fanfare_done = 1'b0; pz_fan = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (go !== 1'b0) $display("FAIL rst_go got %b want 0", go); else n_pass++;
    n_checks++; if (piezo !== 1'b0) $display("FAIL rst_piezo got %b want 0", piezo); else n_pass++;
    n_checks++; if (piezo_n !== 1'b0) $display("FAIL rst_piezo_n got %b want 0", piezo_n); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else n_pass++;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n_checks++; if (busy !== 1'b0) $display("FAIL idle_busy k=%0d got %b want 0", k, busy); else n_pass++;
      step();
    end
  endtask

  task automatic test_fanfare();
    logic prev_pz, eb;
    do_reset();
    prev_pz = 1'b0;
    for (int k = 0; k <= 320; k++) begin
      fanfare_req  = (k == 10);
      fanfare_done = (k == 300);
      pz_fan       = k[1] ^ k[4];
      eb = (k >= 12 && k <= 300);
      n_checks++; if (go !== (k == 12)) $display("FAIL fan_go k=%0d got %b want %b", k, go, (k == 12)); else n_pass++;
      n_checks++; if (busy !== eb) $display("FAIL fan_busy k=%0d got %b want %b", k, busy, eb); else n_pass++;
      n_checks++; if (piezo !== (eb & prev_pz)) $display("FAIL fan_piezo k=%0d got %b want %b", k, piezo, eb & prev_pz); else n_pass++;
      n_checks++; if (piezo_n !== (eb & ~prev_pz)) $display("FAIL fan_piezo_n k=%0d got %b want %b", k, piezo_n, eb & ~prev_pz); else n_pass++;
      prev_pz = pz_fan;
      step();
    end
    fanfare_req = 1'b0; fanfare_done = 1'b0; pz_fan = 1'b0;
  endtask

  task automatic test_error();
    logic eb, ib, tn;
    do_reset();
    for (int k = 0; k <= 200; k++) begin
      err_req      = (k == 0);
      fanfare_done = (k == 50);
      eb = (k >= 2 && k <= 181);
      ib = 1'b0; tn = 1'b0;
      for (int w = 0; w < 3; w++) begin
        if (k >= 2 + w * 60 && k < 2 + w * 60 + BL) begin
          ib = 1'b1;
          tn = (((k - (2 + w * 60)) / BH) % 2) == 1;
        end
      end
      n_checks++; if (busy !== eb) $display("FAIL err_busy k=%0d got %b want %b", k, busy, eb); else n_pass++;
      n_checks++; if (go !== 1'b0) $display("FAIL err_go k=%0d got %b want 0", k, go); else n_pass++;
      n_checks++; if (piezo !== (ib & tn)) $display("FAIL err_piezo k=%0d got %b want %b", k, piezo, ib & tn); else n_pass++;
      n_checks++; if (piezo_n !== (ib & ~tn)) $display("FAIL err_piezo_n k=%0d got %b want %b", k, piezo_n, ib & ~tn); else n_pass++;
      step();
    end
    err_req = 1'b0; fanfare_done = 1'b0;
  endtask

  task automatic test_priority();
    logic eb, fan;
    do_reset();
    for (int k = 0; k <= 440; k++) begin
      fanfare_req  = (k == 0);
      err_req      = (k == 0) || (k == 200);
      fanfare_done = (k == 250);
      fan = (k >= 183 && k <= 250);
      eb  = (k >= 2 && k <= 181) || fan || (k >= 252 && k <= 431);
      n_checks++; if (busy !== eb) $display("FAIL pri_busy k=%0d got %b want %b", k, busy, eb); else n_pass++;
      n_checks++; if (go !== (k == 183)) $display("FAIL pri_go k=%0d got %b want %b", k, go, (k == 183)); else n_pass++;
      if (k >= 184 && k <= 250) begin
        n_checks++; if (piezo_n !== 1'b1) $display("FAIL pri_fan_piezo_n k=%0d got %b want 1", k, piezo_n); else n_pass++;
      end
      step();
    end
    fanfare_req = 1'b0; err_req = 1'b0; fanfare_done = 1'b0;
  endtask

  task automatic test_battery();
    logic ib, tn;
    int starts [3];
    starts = '{1, 242, 483};
    do_reset();
    for (int k = 0; k <= 800; k++) begin
      batt_low = (k < 500);
      ib = 1'b0; tn = 1'b0;
      for (int c = 0; c < 3; c++) begin
        if (k >= starts[c] && k < starts[c] + BL) begin
          ib = 1'b1;
          tn = (((k - starts[c]) / BH) % 2) == 1;
        end
      end
      n_checks++; if (busy !== ib) $display("FAIL batt_busy k=%0d got %b want %b", k, busy, ib); else n_pass++;
      n_checks++; if (piezo !== (ib & tn)) $display("FAIL batt_piezo k=%0d got %b want %b", k, piezo, ib & tn); else n_pass++;
      n_checks++; if (piezo_n !== (ib & ~tn)) $display("FAIL batt_piezo_n k=%0d got %b want %b", k, piezo_n, ib & ~tn); else n_pass++;
      step();
    end
    batt_low = 1'b0;
  endtask

  task automatic test_timeout();
    logic eb;
    do_reset();
    pz_fan = 1'b1;
    for (int k = 0; k <= 1010; k++) begin
      fanfare_req  = (k == 0);
      fanfare_done = (k == 1001);
      eb = (k >= 2 && k <= 1001);
      n_checks++; if (busy !== eb) $display("FAIL tmo_busy k=%0d got %b want %b", k, busy, eb); else n_pass++;
      n_checks++; if (go !== (k == 2)) $display("FAIL tmo_go k=%0d got %b want %b", k, go, (k == 2)); else n_pass++;
      n_checks++; if (piezo !== eb) $display("FAIL tmo_piezo k=%0d got %b want %b", k, piezo, eb); else n_pass++;
      step();
    end
    fanfare_req = 1'b0; fanfare_done = 1'b0; pz_fan = 1'b0;
  endtask

  task automatic test_reset_mid_beep();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      err_req     = (k == 0) || (k == 7);
      fanfare_req = (k == 7);
      step();
    end
    err_req = 1'b0; fanfare_req = 1'b0;
    n_checks++; if (piezo !== 1'b1) $display("FAIL mid_piezo_pre got %b want 1", piezo); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL mid_busy_pre got %b want 1", busy); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if ({go, piezo, piezo_n, busy} !== 4'b0000)
      $display("FAIL mid_rst_outs got %b want 0000", {go, piezo, piezo_n, busy}); else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 300; k++) begin
      n_checks++; if ({go, piezo, piezo_n, busy} !== 4'b0000)
        $display("FAIL mid_after k=%0d got %b want 0000", k, {go, piezo, piezo_n, busy}); else n_pass++;
      step();
    end
  endtask

  task automatic test_holdoff_clear();
    do_reset();
    batt_low = 1'b1;
    for (int k = 0; k < 60; k++) step();
    n_checks++; if (busy !== 1'b0) $display("FAIL hold_wait_busy got %b want 0", busy); else n_pass++;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_checks++; if (busy !== 1'b0) $display("FAIL hold_rel_busy got %b want 0", busy); else n_pass++;
    step();
    n_checks++; if (busy !== 1'b1) $display("FAIL hold_chirp_busy got %b want 1", busy); else n_pass++;
    batt_low = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fanfare();
    test_error();
    test_priority();
    test_battery();
    test_timeout();
    test_reset_mid_beep();
    test_holdoff_clear();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/piezo_arb.md
# piezo_arb

Arbitrates the single piezo bender between three sound sources: the fanfare tune player (`sponge`, started after each completed knight move), a 3-beep error alert for rejected commands, and a periodic low-battery chirp. It sits between the command processor / battery monitor and the piezo pins. It starts `sponge` with a one-cycle `go` and muxes its output. Beeps come from an internal square-wave generator. Only one sound plays at a time and none is preempted.

## Interface
- `BEEP_HALF`, 25000: tone half-period in clocks (1 kHz at 50 MHz).
- `BEEP_LEN`, 5000000: beep duration in clocks.
- `GAP_LEN`, 2500000: silence after each error beep, in clocks.
- `FAN_TMO`, 33554432: maximum fanfare length in clocks before forced abort.
- `BATT_PERIOD`, 100000000: minimum clocks from the end of one battery chirp to the start of the next.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `fanfare_req` in 1: one-cycle pulse when a knight move completes.
- `err_req` in 1: one-cycle pulse when a command is rejected.
- `batt_low` in 1: level, high while the battery is low.
- `fanfare_done` in 1: one-cycle pulse from `sponge` at the end of its tune.
- `pz_fan` in 1: piezo drive from `sponge`.
- `go` out 1: one-cycle start pulse to `sponge`.
- `piezo` out 1: piezo drive.
- `piezo_n` out 1: complementary piezo drive.
- `busy` out 1: high while any sound or error gap is in progress.

## Operation
- **Pending flags.** `pend_err` and `pend_fan` are set by their request pulses. They are cleared when their sound starts.
  - A request arriving while that same sound is playing sets the flag again, so exactly one repeat is queued.
  - Further requests before service are absorbed into the same flag.
- **Battery eligibility.** Battery is eligible when `batt_low`=1 and the holdoff counter is 0.
- **Priority in IDLE.** err > fanfare > battery.
- **States:** IDLE, FAN, ERR_BEEP, ERR_GAP, BATT_BEEP.
- **IDLE → FAN.** Clear `pend_fan`, pulse `go`, and start the timeout counter.
  - FAN → IDLE on `fanfare_done`, or when the counter reaches `FAN_TMO`-1.
- **IDLE → ERR_BEEP.** Clear `pend_err` and set the beep count to 0.
  - ERR_BEEP lasts `BEEP_LEN` clocks, then goes to ERR_GAP.
  - ERR_GAP lasts `GAP_LEN` clocks.
  - At the end of ERR_GAP: increment the count; go to ERR_BEEP if the count < 3, else to IDLE.
- **IDLE → BATT_BEEP.** BATT_BEEP lasts `BEEP_LEN` clocks, then goes to IDLE.
  - On exit, load the holdoff counter with `BATT_PERIOD`.
  - The holdoff counter decrements in every state until it reaches 0.
  - If `batt_low` drops, no further chirps occur. A chirp already in progress still finishes.
- **Piezo outputs.**
  - FAN: `piezo`=`pz_fan`, `piezo_n`=~`pz_fan`.
  - ERR_BEEP and BATT_BEEP: `piezo`=tone, `piezo_n`=~tone. The tone restarts low on beep entry and toggles every `BEEP_HALF` clocks.
  - All other states: `piezo`=`piezo_n`=0, so there is no DC across the bender.
- **`busy`** = (state ≠ IDLE).
- **Width.** Each counter is `$clog2` of its parameter, 1 bit minimum, unsigned. Compares are equality against parameter-1, so counters cannot wrap.
- **Simultaneous events:**
  - A `fanfare_done` arriving outside FAN is ignored.
  - A `fanfare_done` arriving in the same cycle as the timeout gives a single return to IDLE.
  - A request arriving in the cycle its flag is cleared sets the flag (set wins).

## Timing
- **Reset values.** All outputs are 0, state is IDLE, all flags and counters are 0. Reset is asynchronous.
- **Reset mid-sound.** The sound stops immediately, pending requests are dropped, and the holdoff is cleared.
- **Fanfare start.** `fanfare_req` high in cycle 0 → `pend_fan` set at the edge ending cycle 0 → `go`=1 and `busy`=1 in cycle 2. `go` is high for exactly one cycle.
- **Error alert.** `err_req` in cycle 0 → `busy` rises in cycle 2.
  - Tone is active for 3 windows of `BEEP_LEN` cycles, each followed by `GAP_LEN` cycles of silence.
  - `busy` falls 3·(`BEEP_LEN`+`GAP_LEN`) cycles after it rises.
- **Return to service.** After any return to IDLE, the next pending sound starts 1 cycle later.
- **Registered outputs.** `go` is registered. `piezo` and `piezo_n` are registered (one cycle behind `pz_fan` in FAN).

## Structure
- **`piezo_arb_pkg`:**
  - `state_t` enum for the five states.
  - Localparam `ERR_BEEPS` = 3.
  - Default cycle constants for all parameters.
  - Reduced FAST_SIM constants for benches.
- **Sub-module `beep_tone`:** inputs `clk`, `rst_n`, `en`; parameter `HALF`; output `tone`. It restarts low whenever `en` rises.

## Test plan
All scenarios use bench parameters `BEEP_HALF`=4, `BEEP_LEN`=40, `GAP_LEN`=20, `FAN_TMO`=1000, `BATT_PERIOD`=200.
- **Fanfare.** `fanfare_req` pulse at cycle 10, `fanfare_done` at cycle 300 → `go`=1 only in cycle 12, `piezo` tracks `pz_fan` delayed 1 cycle, `busy` falls at cycle 301.
- **Error.** `err_req` pulse → 3 bursts of 40 cycles of tone with period 8, separated by 20 silent cycles, then `busy`=0. `piezo` and `piezo_n` are both 0 during the gaps.
- **Priority.** `fanfare_req` and `err_req` in the same cycle → error sequence first. `go` fires 1 cycle after the error sequence ends. A second `err_req` during the fanfare queues one more error sequence.
- **Battery.** `batt_low` held high → 40-cycle chirps whose starts are 241 cycles apart. `batt_low` dropped mid-chirp → that chirp completes and no further chirps occur.
- **Timeout and reset.** No `fanfare_done` → FAN exits after 1000 cycles. `rst_n` asserted mid-beep → all outputs 0 in the same cycle, and nothing plays after release.
